// File: rtl/xadc_drp_sampler.sv
// xadc_drp_sampler
//   Reads one XADC status register over DRP at a fixed sample rate. The
//   8 MSBs of each 12-bit result go to the low-pass filter input.
// Ports:
//   clk, rst (synchronous, active-low), enable (sampling on when high)
//   DRP master : drp_daddr (constant DRP_ADDR), drp_den (one-cycle read pulse),
//                drp_dwe (tied 0), drp_do (read data), drp_drdy (data ready)
//   Sample out : sig_out, sig_valid (one-cycle strobe on update)
//   Status     : timeout_err, overrun_err (sticky until reset)
// Build option:
//   XADC_AVG_EN -- when defined, publish the average of four captures
//   instead of every capture.
module xadc_drp_sampler #(
  parameter int unsigned CLK_DIV  = 1000,
  parameter logic [6:0]  DRP_ADDR = 7'h16,
  parameter int unsigned TIMEOUT  = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        enable,
  output logic [6:0]  drp_daddr,
  output logic        drp_den,
  output logic        drp_dwe,
  input  logic [15:0] drp_do,
  input  logic        drp_drdy,
  output logic [7:0]  sig_out,
  output logic        sig_valid,
  output logic        timeout_err,
  output logic        overrun_err
);

  localparam int unsigned DIV_W = 16;
  localparam int unsigned TO_W  = 8;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [TO_W-1:0]  TO_LAST  = TO_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_REQ,
    S_WAIT,
    S_CAPTURE
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [DIV_W-1:0] r_div;
  logic [TO_W-1:0]  r_tcnt;
  logic             r_den;
  logic             r_valid;
  logic [7:0]       r_sig;
  logic             r_terr;
  logic             r_oerr;

  logic             w_tick;
  logic             w_start;
  logic             w_capture;
  logic             w_timeout;
  logic             w_overrun;
  logic             w_publish;
  logic [7:0]       w_sample;

  assign drp_daddr   = DRP_ADDR;
  assign drp_dwe     = 1'b0;
  assign drp_den     = r_den;
  assign sig_out     = r_sig;
  assign sig_valid   = r_valid;
  assign timeout_err = r_terr;
  assign overrun_err = r_oerr;

  // Sample-rate divider: tick on the wrap cycle, parked at zero while disabled
  assign w_tick = enable && (r_div == DIV_LAST);

  always_ff @(posedge clk) begin
    if (!rst || !enable || w_tick) begin
      r_div <= '0;
    end else begin
      r_div <= r_div + DIV_W'(1);
    end
  end

  // FSM state register
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // FSM next-state and event decode
  always_comb begin
    w_state_nxt = r_state;
    w_start     = 1'b0;
    w_capture   = 1'b0;
    w_timeout   = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_tick) begin
          w_state_nxt = S_REQ;
          w_start     = 1'b1;
        end
      end
      S_REQ: begin
        w_state_nxt = S_WAIT;
      end
      S_WAIT: begin
        if (drp_drdy) begin
          w_state_nxt = S_CAPTURE;
          w_capture   = 1'b1;
        end else if (r_tcnt == TO_LAST) begin
          w_state_nxt = S_IDLE;
          w_timeout   = 1'b1;
        end
      end
      S_CAPTURE: begin
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // A tick that lands while a read is in flight is dropped and flagged
  assign w_overrun = w_tick && (r_state != S_IDLE);

  // WAIT-cycle counter; zero everywhere outside WAIT so each read starts fresh
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_tcnt <= '0;
    end else if ((r_state == S_WAIT) && (w_state_nxt == S_WAIT)) begin
      r_tcnt <= r_tcnt + TO_W'(1);
    end else begin
      r_tcnt <= '0;
    end
  end

  // Registered DRP strobe, sample output and sticky status
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_den   <= 1'b0;
      r_valid <= 1'b0;
      r_sig   <= '0;
      r_terr  <= 1'b0;
      r_oerr  <= 1'b0;
    end else begin
      r_den   <= w_start;
      r_valid <= w_publish;
      if (w_publish) begin
        r_sig <= w_sample;
      end
      if (w_timeout) begin
        r_terr <= 1'b1;
      end
      if (w_overrun) begin
        r_oerr <= 1'b1;
      end
    end
  end

`ifdef XADC_AVG_EN
  localparam int unsigned ACC_W = 18;

  logic [ACC_W-1:0] r_acc;
  logic [1:0]       r_cnt;
  logic [ACC_W-1:0] w_acc_sum;

  // Sum of four 16-bit words: the top byte of the 18-bit sum is the mean's MSBs
  assign w_acc_sum = r_acc + ACC_W'(drp_do);
  assign w_publish = w_capture && (r_cnt == 2'd3);
  assign w_sample  = w_acc_sum[ACC_W-1:ACC_W-8];

  // Accumulator advances only on a real capture, so timeouts do not count
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_acc <= '0;
      r_cnt <= '0;
    end else if (w_publish) begin
      r_acc <= '0;
      r_cnt <= '0;
    end else if (w_capture) begin
      r_acc <= w_acc_sum;
      r_cnt <= r_cnt + 2'd1;
    end
  end
`else
  logic w_unused;

  // Every capture publishes the top byte of the 12-bit result
  assign w_publish = w_capture;
  assign w_sample  = drp_do[15:8];
  assign w_unused  = ^drp_do[7:0];
`endif

endmodule

// File: tb/tb_xadc_drp_sampler.sv
// Bench for xadc_drp_sampler: directed vector table, corner-case sequences and
// randomized traffic checked every cycle against a timestamp-based read model.
module tb_xadc_drp_sampler;

  localparam int         CLK_DIV  = 8;
  localparam int         TIMEOUT  = 10;
  localparam logic [6:0] DRP_ADDR = 7'h16;

  logic        clk = 1'b0;
  logic        rst;
  logic        enable;
  logic [6:0]  drp_daddr;
  logic        drp_den;
  logic        drp_dwe;
  logic [15:0] drp_do;
  logic        drp_drdy;
  logic [7:0]  sig_out;
  logic        sig_valid;
  logic        timeout_err;
  logic        overrun_err;

  int checks = 0;
  int errors = 0;
  int v_cnt  = 0;
  int d_cnt  = 0;

  // Reference model: a read is described by its tick cycle and capture cycle
  int         m_t;
  int         m_n;
  bit         m_active;
  int         m_s;
  int         m_cap;
  int         m_acc;
  int         m_cnt;
  bit         e_den;
  bit         e_valid;
  logic [7:0] e_sig;
  bit         e_terr;
  bit         e_oerr;

  xadc_drp_sampler #(
    .CLK_DIV (CLK_DIV),
    .DRP_ADDR(DRP_ADDR),
    .TIMEOUT (TIMEOUT)
  ) u_dut (
    .clk        (clk),
    .rst        (rst),
    .enable     (enable),
    .drp_daddr  (drp_daddr),
    .drp_den    (drp_den),
    .drp_dwe    (drp_dwe),
    .drp_do     (drp_do),
    .drp_drdy   (drp_drdy),
    .sig_out    (sig_out),
    .sig_valid  (sig_valid),
    .timeout_err(timeout_err),
    .overrun_err(overrun_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_t = 0; m_n = 0; m_active = 1'b0; m_s = 0; m_cap = -1;
    m_acc = 0; m_cnt = 0;
    e_den = 1'b0; e_valid = 1'b0; e_sig = 8'h00; e_terr = 1'b0; e_oerr = 1'b0;
  endtask

  task automatic model_check();
    chk("model_den",   32'(drp_den),     32'(e_den));
    chk("model_valid", 32'(sig_valid),   32'(e_valid));
    chk("model_sig",   32'(sig_out),     32'(e_sig));
    chk("model_terr",  32'(timeout_err), 32'(e_terr));
    chk("model_oerr",  32'(overrun_err), 32'(e_oerr));
    chk("model_addr",  32'(drp_daddr),   32'(DRP_ADDR));
    chk("model_dwe",   32'(drp_dwe),     32'd0);
  endtask

  // Predict the outputs that follow the clock edge consuming these inputs
  task automatic model_adv(input bit r, input bit en, input bit dr, input logic [15:0] d);
    bit tick;
    e_den   = 1'b0;
    e_valid = 1'b0;
    if (!r) begin
      model_reset();
    end else begin
      tick = en && (((m_n + 1) % CLK_DIV) == 0);
      m_n  = en ? m_n + 1 : 0;
      if (m_active) begin
        if (tick) e_oerr = 1'b1;
        if (m_cap == m_t) begin
          m_active = 1'b0;
        end else if (m_cap < 0 && m_t >= m_s + 2) begin
          if (dr) begin
            m_cap = m_t + 1;
`ifdef XADC_AVG_EN
            m_acc += int'(d);
            m_cnt++;
            if (m_cnt == 4) begin
              e_valid = 1'b1;
              e_sig   = 8'(m_acc / 1024);
              m_acc   = 0;
              m_cnt   = 0;
            end
`else
            e_valid = 1'b1;
            e_sig   = 8'(d / 16'd256);
`endif
          end else if (m_t == m_s + 1 + TIMEOUT) begin
            e_terr   = 1'b1;
            m_active = 1'b0;
          end
        end
      end else if (tick) begin
        m_active = 1'b1;
        m_s      = m_t;
        m_cap    = -1;
        e_den    = 1'b1;
      end
    end
    m_t++;
  endtask

  // One clock: check current outputs, drive inputs, predict, advance
  task automatic step(input bit r, input bit en, input bit dr, input logic [15:0] d);
    model_check();
    rst      = r;
    enable   = en;
    drp_drdy = dr;
    drp_do   = d;
    model_adv(r, en, dr, d);
    @(negedge clk);
    if (sig_valid) v_cnt++;
    if (drp_den)   d_cnt++;
  endtask

  // Let any read finish and park the divider at zero
  task automatic quiesce();
    repeat (TIMEOUT + 4) step(1'b1, 1'b0, 1'b0, 16'h0000);
    v_cnt = 0;
    d_cnt = 0;
  endtask

  task automatic ticks_to_den(input string name);
    repeat (CLK_DIV) step(1'b1, 1'b1, 1'b0, 16'h0000);
    chk(name, 32'(drp_den), 32'd1);
  endtask

  typedef struct {
    bit          en;
    bit          drdy;
    logic [15:0] dout;
    bit          den;
    bit          valid;
    logic [7:0]  sig;
  } vec_t;

  vec_t        tbl[20];
  logic [15:0] avg_data[4];
  logic [7:0]  prev_sig;

  initial begin
    // Directed vectors from reset: ticks at rows 7 and 15, drdy 3 cycles after
    // the first den, drdy in IDLE and REQ ignored
    for (int i = 0; i < 20; i++) begin
      tbl[i] = '{en: 1'b1, drdy: 1'b0, dout: 16'h0000,
                 den: (i == 7 || i == 15), valid: 1'b0, sig: 8'h00};
    end
    tbl[5].drdy  = 1'b1; tbl[5].dout  = 16'hFFFF;
    tbl[8].drdy  = 1'b1; tbl[8].dout  = 16'hEEEE;
    tbl[11].drdy = 1'b1; tbl[11].dout = 16'hA5F0;
    tbl[18].drdy = 1'b1; tbl[18].dout = 16'h3C0F;
`ifndef XADC_AVG_EN
    tbl[11].valid = 1'b1;
    tbl[18].valid = 1'b1;
    for (int i = 11; i < 20; i++) tbl[i].sig = (i < 18) ? 8'hA5 : 8'h3C;
`endif
    avg_data[0] = 16'h1000; avg_data[1] = 16'h2000;
    avg_data[2] = 16'h3000; avg_data[3] = 16'h4000;

    rst = 1'b0; enable = 1'b0; drp_drdy = 1'b0; drp_do = 16'h0000;
    model_reset();
    repeat (2) @(negedge clk);
    chk("rst_den",  32'(drp_den),     32'd0);
    chk("rst_valid", 32'(sig_valid),  32'd0);
    chk("rst_sig",  32'(sig_out),     32'h00);
    chk("rst_terr", 32'(timeout_err), 32'd0);
    chk("rst_oerr", 32'(overrun_err), 32'd0);
    chk("rst_addr", 32'(drp_daddr),   32'(DRP_ADDR));
    chk("rst_dwe",  32'(drp_dwe),     32'd0);

    for (int i = 0; i < 20; i++) begin
      step(1'b1, tbl[i].en, tbl[i].drdy, tbl[i].dout);
      chk($sformatf("tbl%0d_den", i),   32'(drp_den),   32'(tbl[i].den));
      chk($sformatf("tbl%0d_valid", i), 32'(sig_valid), 32'(tbl[i].valid));
      chk($sformatf("tbl%0d_sig", i),   32'(sig_out),   32'(tbl[i].sig));
    end

    // Timeout: no drdy, enable low so no overrun; then a normal read
    quiesce();
    prev_sig = e_sig;
    ticks_to_den("to_den");
    step(1'b1, 1'b0, 1'b0, 16'h0000);
    repeat (TIMEOUT - 1) step(1'b1, 1'b0, 1'b0, 16'h0000);
    chk("to_terr_before", 32'(timeout_err), 32'd0);
    step(1'b1, 1'b0, 1'b0, 16'h0000);
    chk("to_terr_after", 32'(timeout_err), 32'd1);
    chk("to_sig_kept",   32'(sig_out),     32'(prev_sig));
    chk("to_no_valid",   32'(v_cnt),       32'd0);
    chk("to_oerr",       32'(overrun_err), 32'd0);
    ticks_to_den("to_next_den");
    step(1'b1, 1'b0, 1'b0, 16'h0000);
    step(1'b1, 1'b0, 1'b1, 16'h7700);
`ifndef XADC_AVG_EN
    chk("to_next_valid", 32'(sig_valid), 32'd1);
    chk("to_next_sig",   32'(sig_out),   32'h77);
`endif

    // Overrun: enable stays high, drdy 8 cycles after den, tick lands in WAIT
    quiesce();
    ticks_to_den("ov_den");
    repeat (CLK_DIV - 1) step(1'b1, 1'b1, 1'b0, 16'h0000);
    chk("ov_oerr_before", 32'(overrun_err), 32'd0);
    step(1'b1, 1'b1, 1'b0, 16'h0000);
    chk("ov_oerr_after", 32'(overrun_err), 32'd1);
    step(1'b1, 1'b1, 1'b1, 16'hC300);
    repeat (6) step(1'b1, 1'b1, 1'b0, 16'h0000);
`ifndef XADC_AVG_EN
    chk("ov_one_valid", 32'(v_cnt),   32'd1);
    chk("ov_sig",       32'(sig_out), 32'hC3);
`endif

    // Enable dropped during REQ: read completes, no further den
    quiesce();
    ticks_to_den("en_den");
    d_cnt = 0;
    step(1'b1, 1'b0, 1'b0, 16'h0000);
    step(1'b1, 1'b0, 1'b0, 16'h0000);
    step(1'b1, 1'b0, 1'b1, 16'h5A00);
`ifndef XADC_AVG_EN
    chk("en_valid", 32'(sig_valid), 32'd1);
    chk("en_sig",   32'(sig_out),   32'h5A);
`endif
    repeat (30) step(1'b1, 1'b0, 1'b0, 16'h0000);
    chk("en_no_den", 32'(d_cnt), 32'd0);

    // Reset for one cycle while in WAIT, then a late drdy
    quiesce();
    ticks_to_den("rw_den");
    step(1'b1, 1'b0, 1'b0, 16'h0000);
    step(1'b0, 1'b0, 1'b0, 16'h0000);
    chk("rw_den0",  32'(drp_den),     32'd0);
    chk("rw_valid", 32'(sig_valid),   32'd0);
    chk("rw_sig",   32'(sig_out),     32'h00);
    chk("rw_terr",  32'(timeout_err), 32'd0);
    chk("rw_oerr",  32'(overrun_err), 32'd0);
    v_cnt = 0;
    step(1'b1, 1'b0, 1'b1, 16'hFFFF);
    repeat (4) step(1'b1, 1'b0, 1'b0, 16'h0000);
    chk("rw_no_valid", 32'(v_cnt),   32'd0);
    chk("rw_sig_hold", 32'(sig_out), 32'h00);

    // Four reads of 1000/2000/3000/4000
    v_cnt = 0;
    for (int k = 0; k < 4; k++) begin
      ticks_to_den($sformatf("avg%0d_den", k));
      step(1'b1, 1'b0, 1'b0, 16'h0000);
      step(1'b1, 1'b0, 1'b1, avg_data[k]);
      step(1'b1, 1'b0, 1'b0, 16'h0000);
    end
`ifdef XADC_AVG_EN
    chk("avg_valids", 32'(v_cnt),   32'd1);
    chk("avg_sig",    32'(sig_out), 32'h28);
`else
    chk("avg_valids", 32'(v_cnt),   32'd4);
    chk("avg_sig",    32'(sig_out), 32'h40);
`endif

    // Randomized traffic against the model
    for (int i = 0; i < 3000; i++) begin
      step(($urandom_range(0, 399) != 0),
           ($urandom_range(0, 99) < 90),
           ($urandom_range(0, 5) == 0),
           16'($urandom));
    end
    model_check();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
